// File: rtl/axis_biquad.sv
// Direct Form I biquad on AXI4-Stream: one output sample per accepted input sample, 1-cycle latency.
// Define AXIS_BIQUAD_SATURATION_EN to clamp the internal/output reductions; otherwise they wrap.
module axis_biquad #(
  parameter int inout_width               = 16,
  parameter int inout_decimal_width       = 15,
  parameter int coefficient_width         = 20,
  parameter int coefficient_decimal_width = 18,
  parameter int internal_width            = 20,
  parameter int internal_decimal_width    = 18
) (
  input  logic                                aclk,
  input  logic                                reset,
  input  logic signed [inout_width-1:0]       s_axis_tdata,
  input  logic                                s_axis_tlast,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  output logic signed [inout_width-1:0]       m_axis_tdata,
  output logic                                m_axis_tlast,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  input  logic signed [coefficient_width-1:0] b0,
  input  logic signed [coefficient_width-1:0] b1,
  input  logic signed [coefficient_width-1:0] b2,
  input  logic signed [coefficient_width-1:0] a1,
  input  logic signed [coefficient_width-1:0] a2
);
  localparam int IW = inout_width;
  localparam int CW = coefficient_width;
  localparam int CD = coefficient_decimal_width;
  localparam int NW = internal_width;
  localparam int D  = internal_decimal_width - inout_decimal_width;
  localparam int PW = NW + CW;
  localparam int SW = PW + 3;

  logic signed [NW-1:0] x1_reg, x2_reg, y1_reg, y2_reg;
  logic signed [IW-1:0] tdata_reg;
  logic                 tlast_reg, tvalid_reg;
  logic                 accept;
  logic signed [NW-1:0] x_ext, x_cur, y_cur, y_shr;
  logic signed [IW-1:0] out_cur;
  logic signed [NW-1:0] tap_data [5];
  logic signed [CW-1:0] tap_coef [5];
  logic signed [PW-1:0] prod [5];
  logic signed [SW-1:0] acc, acc_shr;

  assign s_axis_tready = !tvalid_reg || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign x_ext = NW'(s_axis_tdata);
  assign x_cur = x_ext <<< D;

  assign tap_data[0] = x_cur;
  assign tap_data[1] = x1_reg;
  assign tap_data[2] = x2_reg;
  assign tap_data[3] = y1_reg;
  assign tap_data[4] = y2_reg;
  assign tap_coef[0] = b0;
  assign tap_coef[1] = b1;
  assign tap_coef[2] = b2;
  assign tap_coef[3] = a1;
  assign tap_coef[4] = a2;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_tap
      assign prod[gi] = PW'(tap_data[gi]) * PW'(tap_coef[gi]);
    end
  endgenerate

  // Full-precision sum; the single quantisation point is the floor shift below.
  always_comb begin
    acc = SW'(prod[0]) + SW'(prod[1]) + SW'(prod[2]) - SW'(prod[3]) - SW'(prod[4]);
  end
  assign acc_shr = acc >>> CD;
  assign y_shr   = y_cur >>> D;

`ifdef AXIS_BIQUAD_SATURATION_EN
  localparam logic signed [NW-1:0] NW_MAX = {1'b0, {(NW-1){1'b1}}};
  localparam logic signed [NW-1:0] NW_MIN = {1'b1, {(NW-1){1'b0}}};
  localparam logic signed [IW-1:0] IW_MAX = {1'b0, {(IW-1){1'b1}}};
  localparam logic signed [IW-1:0] IW_MIN = {1'b1, {(IW-1){1'b0}}};

  always_comb begin
    y_cur = acc_shr[NW-1:0];
    if (acc_shr[SW-1:NW-1] != {(SW-NW+1){acc_shr[SW-1]}})
      y_cur = acc_shr[SW-1] ? NW_MIN : NW_MAX;
  end

  always_comb begin
    out_cur = y_shr[IW-1:0];
    if (y_shr[NW-1:IW-1] != {(NW-IW+1){y_shr[NW-1]}})
      out_cur = y_shr[NW-1] ? IW_MIN : IW_MAX;
  end
`else
  logic unused_bits;
  assign y_cur       = acc_shr[NW-1:0];
  assign out_cur     = y_shr[IW-1:0];
  assign unused_bits = ^{acc_shr[SW-1:NW], y_shr[NW-1:IW]};
`endif

  always_ff @(posedge aclk) begin
    if (reset) begin
      x1_reg     <= '0;
      x2_reg     <= '0;
      y1_reg     <= '0;
      y2_reg     <= '0;
      tdata_reg  <= '0;
      tlast_reg  <= 1'b0;
      tvalid_reg <= 1'b0;
    end else if (accept) begin
      x2_reg     <= x1_reg;
      x1_reg     <= x_cur;
      y2_reg     <= y1_reg;
      y1_reg     <= y_cur;
      tdata_reg  <= out_cur;
      tlast_reg  <= s_axis_tlast;
      tvalid_reg <= 1'b1;
    end else if (m_axis_tready) begin
      tvalid_reg <= 1'b0;
    end
  end

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tlast  = tlast_reg;
  assign m_axis_tvalid = tvalid_reg;
endmodule

// File: tb/tb_axis_biquad.sv
// Scoreboard bench for axis_biquad: a 64-bit reference model pushes expected outputs on accept.
module tb_axis_biquad;
  localparam int IW = 16;
  localparam int NW = 20;
  localparam int CD = 18;
  localparam int D  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [IW-1:0] s_data = '0;
  logic s_last = 1'b0, s_valid = 1'b0, m_ready = 1'b1;
  logic s_axis_tready, m_axis_tlast, m_axis_tvalid;
  logic signed [IW-1:0] m_axis_tdata;
  logic signed [19:0] b0 = '0, b1 = '0, b2 = '0, a1 = '0, a2 = '0;

  int vectors = 0;
  int miscompares = 0;
  longint mx1 = 0, mx2 = 0, my1 = 0, my2 = 0;
  logic [IW:0] sb [$];

  always #5 clk = ~clk;

  axis_biquad dut (
    .aclk(clk), .reset(reset),
    .s_axis_tdata(s_data), .s_axis_tlast(s_last), .s_axis_tvalid(s_valid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_ready),
    .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2)
  );

  function automatic longint reduce(input longint v, input int w);
    longint hi, lo, m;
    hi = (64'sd1 <<< (w - 1)) - 1;
    lo = -(64'sd1 <<< (w - 1));
`ifdef AXIS_BIQUAD_SATURATION_EN
    m = (v > hi) ? hi : ((v < lo) ? lo : v);
`else
    m = v & ((64'sd1 <<< w) - 1);
    if (m > hi) m = m + lo + lo;
`endif
    return m;
  endfunction

  function automatic void model_push(input logic signed [IW-1:0] din, input logic last);
    longint xi, acc, y, o;
    xi  = reduce(longint'(din) <<< D, NW);
    acc = longint'(b0) * xi + longint'(b1) * mx1 + longint'(b2) * mx2
        - longint'(a1) * my1 - longint'(a2) * my2;
    y   = reduce(acc >>> CD, NW);
    o   = reduce(y >>> D, IW);
    mx2 = mx1; mx1 = xi; my2 = my1; my1 = y;
    sb.push_back({last, o[IW-1:0]});
  endfunction

  task automatic apply_reset();
    reset = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
    sb.delete();
  endtask

  task automatic set_lowpass();
    b0 = 20'sd256; b1 = 20'sd513; b2 = 20'sd256; a1 = -20'sd519991; a2 = 20'sd258873;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    reset = 1'b0; set_lowpass();
    s_data = 16'sd1234; s_valid = 1'b1; m_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    repeat (10) @(posedge clk); #1;
    reset = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    #1;
    vectors += 4;
    if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    if (m_axis_tdata !== 16'sd0) begin miscompares++; $display("FAIL reset_tdata: got %0d want 0", m_axis_tdata); end
    if (m_axis_tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
    if (s_axis_tready !== 1'b1) begin miscompares++; $display("FAIL reset_tready: got %b want 1", s_axis_tready); end
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
    sb.delete();
  endtask

  task automatic test_impulse();
    int sent = 0;
    logic exp_valid;
    apply_reset(); set_lowpass();
    for (int i = 0; i < 260; i++) begin
      s_valid = (sent < 250); s_data = (sent == 0) ? 16'sd1000 : 16'sd0; s_last = 1'b0; m_ready = 1'b1;
      #1;
      exp_valid = (sb.size() != 0);
      vectors++;
      if (m_axis_tvalid !== exp_valid || s_axis_tready !== (!exp_valid || m_ready)) begin
        miscompares++;
        $display("FAIL impulse_hs[%0d]: tvalid=%b tready=%b want %b %b", i, m_axis_tvalid, s_axis_tready, exp_valid, !exp_valid || m_ready);
      end
      if (exp_valid) begin
        vectors++;
        if ({m_axis_tlast, m_axis_tdata} !== sb[0]) begin
          miscompares++; $display("FAIL impulse_data[%0d]: got %h want %h", i, {m_axis_tlast, m_axis_tdata}, sb[0]);
        end
        if (m_ready) void'(sb.pop_front());
      end
      if (s_valid && (!exp_valid || m_ready)) begin model_push(s_data, s_last); sent++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_step();
    int sent = 0;
    logic exp_valid;
    apply_reset(); set_lowpass();
    for (int i = 0; i < 6010; i++) begin
      s_valid = (sent < 2000) && (i % 3 == 0); s_data = 16'sd1000; s_last = (sent == 1999); m_ready = 1'b1;
      #1;
      exp_valid = (sb.size() != 0);
      vectors++;
      if (m_axis_tvalid !== exp_valid || s_axis_tready !== (!exp_valid || m_ready)) begin
        miscompares++;
        $display("FAIL step_hs[%0d]: tvalid=%b tready=%b want %b %b", i, m_axis_tvalid, s_axis_tready, exp_valid, !exp_valid || m_ready);
      end
      if (exp_valid) begin
        vectors++;
        if ({m_axis_tlast, m_axis_tdata} !== sb[0]) begin
          miscompares++; $display("FAIL step_data[%0d]: got %h want %h", i, {m_axis_tlast, m_axis_tdata}, sb[0]);
        end
        if (m_ready) void'(sb.pop_front());
      end
      if (s_valid && (!exp_valid || m_ready)) begin model_push(s_data, s_last); sent++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_pressure();
    int sent = 0;
    logic exp_valid;
    for (int i = 0; i < 70; i++) begin
      s_valid = (sent < 50); s_last = (sent % 5 == 4);
      s_data = 16'($urandom_range(2000)) - 16'sd1000;
      m_ready = !((i >= 10 && i < 15) || (i >= 30 && i < 32) || (i % 7 == 6));
      #1;
      exp_valid = (sb.size() != 0);
      vectors++;
      if (m_axis_tvalid !== exp_valid || s_axis_tready !== (!exp_valid || m_ready)) begin
        miscompares++;
        $display("FAIL bp_hs[%0d]: tvalid=%b tready=%b want %b %b", i, m_axis_tvalid, s_axis_tready, exp_valid, !exp_valid || m_ready);
      end
      if (exp_valid) begin
        vectors++;
        if ({m_axis_tlast, m_axis_tdata} !== sb[0]) begin
          miscompares++; $display("FAIL bp_data[%0d]: got %h want %h", i, {m_axis_tlast, m_axis_tdata}, sb[0]);
        end
        if (m_ready) void'(sb.pop_front());
      end
      if (s_valid && (!exp_valid || m_ready)) begin model_push(s_data, s_last); sent++; end
      @(posedge clk); #1;
    end
  endtask

  // Coefficients change without a reset: the lowpass history stays in the delay line.
  task automatic test_passthrough();
    int sent = 0;
    logic exp_valid;
    b0 = 20'sd262144; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
    for (int i = 0; i < 70; i++) begin
      s_valid = (sent < 64); s_last = (sent % 8 == 7); s_data = 16'($urandom); m_ready = 1'b1;
      #1;
      exp_valid = (sb.size() != 0);
      vectors++;
      if (m_axis_tvalid !== exp_valid || s_axis_tready !== (!exp_valid || m_ready)) begin
        miscompares++;
        $display("FAIL pass_hs[%0d]: tvalid=%b tready=%b want %b %b", i, m_axis_tvalid, s_axis_tready, exp_valid, !exp_valid || m_ready);
      end
      if (exp_valid) begin
        vectors++;
        if ({m_axis_tlast, m_axis_tdata} !== sb[0]) begin
          miscompares++; $display("FAIL pass_data[%0d]: got %h want %h", i, {m_axis_tlast, m_axis_tdata}, sb[0]);
        end
        if (m_ready) void'(sb.pop_front());
      end
      if (s_valid && (!exp_valid || m_ready)) begin model_push(s_data, s_last); sent++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overflow();
    int sent = 0;
    logic exp_valid;
    apply_reset();
    b0 = 20'sd262143; b1 = 20'sd262143; b2 = 20'sd262143; a1 = '0; a2 = '0;
    for (int i = 0; i < 14; i++) begin
      s_valid = (sent < 10); s_last = 1'b0; s_data = (sent < 6) ? 16'sd32767 : -16'sd32768; m_ready = 1'b1;
      #1;
      exp_valid = (sb.size() != 0);
      vectors++;
      if (m_axis_tvalid !== exp_valid || s_axis_tready !== (!exp_valid || m_ready)) begin
        miscompares++;
        $display("FAIL ovf_hs[%0d]: tvalid=%b tready=%b want %b %b", i, m_axis_tvalid, s_axis_tready, exp_valid, !exp_valid || m_ready);
      end
      if (exp_valid) begin
        vectors++;
        if ({m_axis_tlast, m_axis_tdata} !== sb[0]) begin
          miscompares++; $display("FAIL ovf_data[%0d]: got %h want %h", i, {m_axis_tlast, m_axis_tdata}, sb[0]);
        end
        if (m_ready) void'(sb.pop_front());
      end
      if (s_valid && (!exp_valid || m_ready)) begin model_push(s_data, s_last); sent++; end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_step();
    test_back_pressure();
    test_passthrough();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
